// File: rtl/estagio_busca.sv
// rtl/estagio_busca.sv - instruction fetch stage: IDLE/FETCH/HOLD handshake with PC sequencing
// Optional macro IMEM_TIMEOUT_EN adds an ack-wait timeout that raises sticky fetch_err and refetches.
module estagio_busca #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  Funct,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

`ifdef IMEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] to_q, to_d;
    logic          err_q, err_d;
`endif

    assign pc_plus4 = pc_out_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump outranks a taken branch; all sums wrap modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
`ifdef IMEM_TIMEOUT_EN
        to_d     = '0;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = HOLD;
                end
`ifdef IMEM_TIMEOUT_EN
                else if (to_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= '0;
`ifdef IMEM_TIMEOUT_EN
            to_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
`ifdef IMEM_TIMEOUT_EN
            to_q     <= to_d;
            err_q    <= err_d;
`endif
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign OP          = instr_q[31:26];
    assign Funct       = instr_q[5:0];
    assign pc_out      = pc_out_q;

`ifdef IMEM_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
